// File: rtl/ripple_carry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_pkg
// Purpose  : Shared constants and types for the ripple_carry adder and its
//            reference models.
// Contents : RC_DEFAULT_WIDTH - default operand width
//            RC_MAX_WIDTH     - widest supported operand
//            rc_result_t      - {cout, sum} result at the default width
// Revision : 1.0 - initial release
// ============================================================================
package ripple_carry_pkg;

  localparam int RC_DEFAULT_WIDTH = 4;
  localparam int RC_MAX_WIDTH     = 64;

  // Carry-out concatenated above the sum, so {cout, sum} == a + b + cin exactly.
  typedef logic [RC_DEFAULT_WIDTH:0] rc_result_t;

endpackage : ripple_carry_pkg
`default_nettype wire

// File: rtl/ripple_carry_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_full_adder
// Purpose  : One-bit combinational full adder, one stage of the ripple chain.
// Ports    : a, b - operand bits
//            ci   - carry in
//            s    - sum bit
//            co   - carry out
// Revision : 1.0 - initial release
// ============================================================================
module ripple_carry_full_adder
  import ripple_carry_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  // Propagate term is shared by the sum and the carry.
  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule : ripple_carry_full_adder
`default_nettype wire

// File: rtl/ripple_carry.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry
// Purpose  : WIDTH-bit ripple-carry adder with a registered result, one cycle
//            of latency, synchronous active-high reset.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous reset, active-high
//            a, b - unsigned operands [WIDTH-1:0]
//            cin  - carry into bit 0
//            sum  - registered (a+b+cin) mod 2^WIDTH
//            cout - registered carry out of bit WIDTH-1
//            ovf  - registered signed overflow (only when the macro
//                   RIPPLE_CARRY_OVF_EN is defined)
// Config   : RIPPLE_CARRY_OVF_EN - adds the ovf output
// Revision : 1.0 - initial release
// ============================================================================
module ripple_carry
  import ripple_carry_pkg::*;
#(
  parameter int WIDTH = RC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RIPPLE_CARRY_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > RC_MAX_WIDTH) begin : g_bad_width
    $error("ripple_carry: WIDTH out of range");
  end

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    ripple_carry_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign sum_d  = w_sum;
  assign cout_d = w_carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef RIPPLE_CARRY_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  // For WIDTH=1 the carry into the MSB is cin itself (w_carry[0]).
  logic ovf_d, ovf_q;

  assign ovf_d = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : ripple_carry
`default_nettype wire

// File: tb/tb_ripple_carry.sv
`default_nettype none
// ============================================================================
// Module   : tb_ripple_carry
// Purpose  : Self-checking bench for ripple_carry at WIDTH = 4, 1 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_carry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4;
  logic [0:0]  a1, b1, sum1;
  logic        cin1, cout1;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;
  logic        ovf4, ovf1, ovf16;

  ripple_carry #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4)
`ifdef RIPPLE_CARRY_OVF_EN
    , .ovf(ovf4)
`endif
  );

  ripple_carry #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1)
`ifdef RIPPLE_CARRY_OVF_EN
    , .ovf(ovf1)
`endif
  );

  ripple_carry #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16)
`ifdef RIPPLE_CARRY_OVF_EN
    , .ovf(ovf16)
`endif
  );

`ifndef RIPPLE_CARRY_OVF_EN
  assign ovf4  = 1'b0;
  assign ovf1  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Two's-complement overflow from plain signed arithmetic.
  function automatic logic ovf_model(input longint ua, input longint ub, input logic c, input int w);
    longint sa, sb, tot, lim;
    lim = longint'(1) << (w - 1);
    sa  = (ua >= lim) ? ua - (lim << 1) : ua;
    sb  = (ub >= lim) ? ub - (lim << 1) : ub;
    tot = sa + sb + longint'(c);
    return (tot > lim - 1) || (tot < -lim);
  endfunction

  // Reference model: result of each edge is the exact sum of the operands
  // present at that edge, or zero when reset is high.
  logic [4:0]  exp4;
  logic [1:0]  exp1;
  logic [16:0] exp16;
  logic        eovf4, eovf1, eovf16;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    exp4   <= rst ? '0 : {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
    exp1   <= rst ? '0 : {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
    exp16  <= rst ? '0 : {1'b0, a16} + {1'b0, b16} + {16'b0, cin16};
    eovf4  <= rst ? 1'b0 : ovf_model(longint'(a4), longint'(b4), cin4, 4);
    eovf1  <= rst ? 1'b0 : ovf_model(longint'(a1), longint'(b1), cin1, 1);
    eovf16 <= rst ? 1'b0 : ovf_model(longint'(a16), longint'(b16), cin16, 16);
    model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("w4_result",  {59'b0, cout4, sum4},   {59'b0, exp4});
      chk("w1_result",  {62'b0, cout1, sum1},   {62'b0, exp1});
      chk("w16_result", {47'b0, cout16, sum16}, {47'b0, exp16});
`ifdef RIPPLE_CARRY_OVF_EN
      chk("w4_ovf",  {63'b0, ovf4},  {63'b0, eovf4});
      chk("w1_ovf",  {63'b0, ovf1},  {63'b0, eovf1});
      chk("w16_ovf", {63'b0, ovf16}, {63'b0, eovf16});
`endif
    end
  end

  // Drive WIDTH=4 operands, wait one edge, check against hand-computed values.
  task automatic dir4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [3:0] es, input logic ec, input logic eo, input string name);
    a4 = ta; b4 = tb; cin4 = tc;
    @(negedge clk);
    chk({name, "_sum"},  {60'b0, sum4},  {60'b0, es});
    chk({name, "_cout"}, {63'b0, cout4}, {63'b0, ec});
`ifdef RIPPLE_CARRY_OVF_EN
    chk({name, "_ovf"},  {63'b0, ovf4},  {63'b0, eo});
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    rst = 1'b1;
    a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
    a1 = 1'b1;    b1 = 1'b1;    cin1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;

    // Two reset edges with all-ones operands: outputs must stay zero.
    @(negedge clk);
    chk("rst1_sum4", {60'b0, sum4}, 64'h0);
    chk("rst1_cout4", {63'b0, cout4}, 64'h0);
    @(negedge clk);
    chk("rst2_sum4", {60'b0, sum4}, 64'h0);
    chk("rst2_cout4", {63'b0, cout4}, 64'h0);
    chk("rst2_sum16", {48'b0, sum16}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_sum4", {60'b0, sum4}, 64'hF);
    chk("first_cout4", {63'b0, cout4}, 64'h1);
    chk("first_sum16", {48'b0, sum16}, 64'hFFFF);
    chk("first_cout16", {63'b0, cout16}, 64'h1);
    chk("first_w1", {62'b0, cout1, sum1}, 64'h3);

    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a16 = '0;  b16 = '0;  cin16 = 1'b0;
    dir4(4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, "basic");
    chk("zero_w16", {47'b0, cout16, sum16}, 64'h0);
    dir4(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, "ripple");
    dir4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "wrap");
    dir4(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0, "cin1");
    dir4(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0, "cin0");
    dir4(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, "zero");
    dir4(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, "ones_cin");

    // Back-to-back random vectors with one mid-run reset pulse.
    for (int i = 0; i < 1000; i++) begin
      a4  = 4'($urandom);  b4  = 4'($urandom);  cin4  = 1'($urandom);
      a1  = 1'($urandom);  b1  = 1'($urandom);  cin1  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      rst = (i == 500);
      @(negedge clk);
      if (i == 500) begin
        chk("midrst_sum4", {60'b0, sum4}, 64'h0);
        chk("midrst_sum16", {47'b0, cout16, sum16}, 64'h0);
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ripple_carry
`default_nettype wire
